// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg
//   Shared definitions for the data-memory responder.
//   - state_e : FSM state encoding (IDLE / WAIT / RESP)
//   - CNT_W   : width of the wait-state counter (Latency is 1..15)
package data_mem_responder_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_if
//   CPU data-memory bus between the initiator (CPU) and the responder.
//   master : drives memRead/memWrite/memAdr/memWriteData, sees ready/data/error
//   slave  : the memory side, mirror image of master
interface data_mem_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAdr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        ready;
  logic        misaligned;

  modport master (
    output memRead, memWrite, memAdr, memWriteData,
    input  memReadData, ready, misaligned
  );

  modport slave (
    input  memRead, memWrite, memAdr, memWriteData,
    output memReadData, ready, misaligned
  );
endinterface

// File: rtl/data_mem_responder_array.sv
// data_mem_array
//   WordCount x 32 storage: synchronous write, combinational read, one
//   shared address. Contents are never reset.
//   clk     : clock, rising edge
//   we_i    : write enable
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : read data at addr_i (combinational)
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int WordCount = 1024,
  localparam int AW = $clog2(WordCount)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [WordCount];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory with a fixed number of wait states. A request
//   seen in IDLE is latched, counted down for Latency cycles, then completed
//   with a single-cycle ready pulse.
//   clk : clock, rising edge
//   rst : asynchronous reset, active low
//   bus : data_mem_if.slave (memRead/memWrite/memAdr/memWriteData in,
//         memReadData/ready/misaligned out)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int WordCount = 1024,
  parameter int Latency   = 2
) (
  input  logic      clk,
  input  logic      rst,
  data_mem_if.slave bus
);

  localparam int AW = $clog2(WordCount);

  if (Latency < 1 || Latency > 15) begin : g_bad_latency
    $error("data_mem_responder: Latency must be in 1..15");
  end

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mis_q, mis_d;

  logic            req;
  logic            done;
  logic            ram_we;
  logic [31:0]     ram_rdata;

  // Address bits above the RAM index are don't-care (accesses wrap).
  logic            unused_adr_hi;
  assign unused_adr_hi = ^bus.memAdr[31:AW+2];

  assign req  = bus.memRead | bus.memWrite;
  // Last wait edge: the access is performed on this edge.
  assign done = (state_q == S_WAIT) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = bus.memAdr[AW+1:2];
          wdata_d = bus.memWriteData;
          // Write wins when both strobes are high.
          wr_d    = bus.memWrite;
          cnt_d   = CNT_W'(Latency - 1);
          state_d = S_WAIT;
          if (bus.memAdr[1:0] != 2'b00) mis_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (done) begin
          if (!wr_q) rdata_d = ram_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ram_we = done && wr_q;
    bus.ready       = (state_q == S_RESP);
    bus.memReadData = rdata_q;
    bus.misaligned  = mis_q;
  end

  data_mem_array #(.WordCount(WordCount)) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench: one responder at Latency=2 (main tests) and one at
//   Latency=1 (back-to-back). Inputs change and outputs are sampled on the
//   falling clock edge.
module tb_data_mem_responder;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  data_mem_if m2();
  data_mem_if m1();

  data_mem_responder #(.WordCount(1024), .Latency(2)) dut2 (
    .clk (clk),
    .rst (rst_n),
    .bus (m2)
  );

  data_mem_responder #(.WordCount(1024), .Latency(1)) dut1 (
    .clk (clk),
    .rst (rst_n),
    .bus (m1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 2) ? m2.ready : m1.ready;
  endfunction

  function automatic logic [31:0] rdat(input int d);
    return (d == 2) ? m2.memReadData : m1.memReadData;
  endfunction

  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [31:0] adr, input logic [31:0] wd);
    if (d == 2) begin
      m2.memRead = rd; m2.memWrite = wr; m2.memAdr = adr; m2.memWriteData = wd;
    end else begin
      m1.memRead = rd; m1.memWrite = wr; m1.memAdr = adr; m1.memWriteData = wd;
    end
  endtask

  // Issue one access and wait for ready. lat = edges from sampling edge to
  // ready rising (-1 on timeout); rd_at = memReadData in the ready cycle.
  // Returns at the falling edge of the ready cycle with the request dropped.
  task automatic acc(input int d, input logic rd, input logic wr,
                     input logic [31:0] adr, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd_at);
    @(negedge clk);
    drive(d, rd, wr, adr, wd);
    lat   = -1;
    rd_at = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rdy(d)) begin
        lat   = i - 1;
        rd_at = rdat(d);
        break;
      end
    end
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  int          lat;
  logic [31:0] rd_at;
  int          nrdy;
  logic [8:0]  pat;

  initial begin
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_ready",  32'(m2.ready),      32'h0);
    chk("rst_rdata",  m2.memReadData,     32'h0);
    chk("rst_mis",    32'(m2.misaligned), 32'h0);
    chk("rst_ready1", 32'(m1.ready),      32'h0);
    rst_n = 1'b1;
    nrdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (m2.ready || m1.ready) nrdy++;
    end
    chk("idle_no_ready", 32'(nrdy), 32'h0);

    // Write then read, Latency=2
    acc(2, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, lat, rd_at);
    chk("wr40_lat", 32'(lat), 32'd2);
    @(negedge clk);
    chk("wr40_ready_pulse", 32'(m2.ready), 32'h0);
    acc(2, 1'b1, 1'b0, 32'h40, 32'h0, lat, rd_at);
    chk("rd40_lat",  32'(lat), 32'd2);
    chk("rd40_data", rd_at, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("rd40_hold", m2.memReadData, 32'hDEADBEEF);

    // Known contents at 0x80 for the reset-abort test
    acc(2, 1'b0, 1'b1, 32'h80, 32'h12345678, lat, rd_at);
    chk("wr80_lat", 32'(lat), 32'd2);

    // Address wrap and write priority
    acc(2, 1'b0, 1'b1, 32'h00001000, 32'h11111111, lat, rd_at);
    acc(2, 1'b1, 1'b0, 32'h0, 32'h0, lat, rd_at);
    chk("wrap_rd0", rd_at, 32'h11111111);
    acc(2, 1'b1, 1'b1, 32'h0, 32'h22222222, lat, rd_at);
    chk("both_lat",    32'(lat), 32'd2);
    chk("both_rdata",  rd_at, 32'h11111111);
    chk("both_no_mis", 32'(m2.misaligned), 32'h0);
    acc(2, 1'b1, 1'b0, 32'h0, 32'h0, lat, rd_at);
    chk("both_rd0", rd_at, 32'h22222222);

    // Misaligned, sticky
    acc(2, 1'b1, 1'b0, 32'h43, 32'h0, lat, rd_at);
    chk("mis_data", rd_at, 32'hDEADBEEF);
    chk("mis_flag", 32'(m2.misaligned), 32'h1);
    acc(2, 1'b1, 1'b0, 32'h80, 32'h0, lat, rd_at);
    chk("mis_rd80",   rd_at, 32'h12345678);
    chk("mis_sticky", 32'(m2.misaligned), 32'h1);

    // Reset during WAIT aborts the write
    @(negedge clk);
    drive(2, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D);
    @(negedge clk);
    chk("abort_in_wait", 32'(m2.ready), 32'h0);
    rst_n = 1'b0;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    nrdy = 0;
    repeat (3) begin
      @(negedge clk);
      if (m2.ready) nrdy++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (m2.ready) nrdy++;
    end
    chk("abort_no_ready", 32'(nrdy), 32'h0);
    chk("abort_rdata",    m2.memReadData, 32'h0);
    chk("abort_mis_clr",  32'(m2.misaligned), 32'h0);
    acc(2, 1'b1, 1'b0, 32'h80, 32'h0, lat, rd_at);
    chk("abort_rd80", rd_at, 32'h12345678);

    // Latency=1 instance: preload, then back-to-back reads
    acc(1, 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, lat, rd_at);
    chk("l1_lat", 32'(lat), 32'd1);
    acc(1, 1'b0, 1'b1, 32'h104, 32'h5A5A5A5A, lat, rd_at);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h100, 32'h0);
    pat = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      pat[k-1] = m1.ready;
      // WAIT cycles of the three accesses: swap the address under the latch
      if (k == 1) m1.memAdr = 32'h104;
      if (k == 4) m1.memAdr = 32'h100;
      if (k == 7) m1.memAdr = 32'h104;
      if (k == 2) chk("b2b_data1", m1.memReadData, 32'hA5A5A5A5);
      if (k == 5) chk("b2b_data2", m1.memReadData, 32'h5A5A5A5A);
      if (k == 8) chk("b2b_data3", m1.memReadData, 32'hA5A5A5A5);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_pattern", 32'(pat), 32'(9'b010010010));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
